// File: rtl/alu_seq_param.sv
// Sequential ALU with a valid/ready handshake: single-cycle logic/arith ops,
// multi-cycle shift-add multiply and restoring divide.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           s,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 carry,
  output logic                 zero,
  output logic                 err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);
  localparam logic [SHW:0]  WVAL = (SHW+1)'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state;
  logic                 r_isDiv;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_divisor;

  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH:0]       w_inc;
  logic [WIDTH:0]       w_dec;
  logic [SHW-1:0]       w_sh;
  logic [SHW-1:0]       w_rotAmt;
  logic [SHW:0]         w_rotInv;
  logic [WIDTH-1:0]     w_rotl;
  logic [WIDTH-1:0]     w_rotr;
  logic [2*WIDTH-1:0]   w_single;
  logic                 w_carry;

  logic [2*WIDTH-1:0]   w_accNext;
  logic [WIDTH:0]       w_shifted;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_remNext;
  logic [WIDTH-1:0]     w_quoNext;
  logic [2*WIDTH-1:0]   w_busyResult;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  assign w_inc = {1'b0, a} + (WIDTH+1)'(1);
  assign w_dec = {1'b0, a} - (WIDTH+1)'(1);

  // Rotates reduce the amount modulo WIDTH so non-power-of-two widths still rotate
  assign w_sh     = b[SHW-1:0];
  assign w_rotAmt = SHW'(32'(w_sh) % WIDTH);
  assign w_rotInv = WVAL - {1'b0, w_rotAmt};
  assign w_rotl   = (a << w_rotAmt) | (a >> w_rotInv);
  assign w_rotr   = (a >> w_rotAmt) | (a << w_rotInv);

  always_comb begin
    w_single = '0;
    w_carry  = 1'b0;
    case (s)
      4'h0: begin w_single = {{(WIDTH-1){1'b0}}, w_add}; w_carry = w_add[WIDTH]; end
      4'h1: begin w_single = {{(WIDTH-1){1'b0}}, w_sub}; w_carry = w_sub[WIDTH]; end
      4'h4: w_single = {{WIDTH{1'b0}}, a & b};
      4'h5: w_single = {{WIDTH{1'b0}}, a | b};
      4'h6: w_single = {{WIDTH{1'b0}}, a ^ b};
      4'h7: w_single = {{WIDTH{1'b0}}, ~a};
      4'h8: w_single = {{WIDTH{1'b0}}, a << w_sh};
      4'h9: w_single = {{WIDTH{1'b0}}, a >> w_sh};
      4'hA: w_single = {{WIDTH{1'b0}}, w_rotl};
      4'hB: w_single = {{WIDTH{1'b0}}, w_rotr};
      4'hC: w_single = {{(2*WIDTH-1){1'b0}}, (a > b)};
      4'hD: begin w_single = {{(WIDTH-1){1'b0}}, w_inc}; w_carry = w_inc[WIDTH]; end
      4'hE: begin w_single = {{(WIDTH-1){1'b0}}, w_dec}; w_carry = w_dec[WIDTH]; end
      4'hF: w_single = {{WIDTH{1'b0}}, b};
      default: w_single = '0;
    endcase
  end

  // One shift-add or restoring-divide iteration per BUSY cycle
  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_divisor};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_remNext = w_ge ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_ge};
  assign w_busyResult = r_isDiv ? {w_remNext, w_quoNext} : w_accNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_isDiv   <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      y         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (s == 4'h2) begin
              r_isDiv  <= 1'b0;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_cnt    <= '0;
              r_state  <= BUSY;
            end else if (s == 4'h3 && b == '0) begin
              y       <= '1;
              carry   <= 1'b0;
              zero    <= 1'b0;
              err     <= 1'b1;
              r_state <= DONE;
            end else if (s == 4'h3) begin
              r_isDiv   <= 1'b1;
              r_rem     <= '0;
              r_quo     <= a;
              r_divisor <= b;
              r_cnt     <= '0;
              r_state   <= BUSY;
            end else begin
              y       <= w_single;
              carry   <= w_carry;
              zero    <= (w_single == '0);
              err     <= 1'b0;
              r_state <= DONE;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_isDiv) begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
          end else begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
          if (r_cnt == LAST) begin
            y       <= w_busyResult;
            carry   <= 1'b0;
            zero    <= (w_busyResult == '0);
            err     <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed scoreboard bench for alu_seq_param: an 8-bit instance for the main
// checks and a 16-bit instance for the wide multiply.
module tb_alu_seq_param;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  a, b;
  logic [3:0]  s;
  logic        in_valid, in_ready, out_ready;
  logic [15:0] y;
  logic        carry, zero, err, out_valid;

  logic [15:0] a16, b16;
  logic [3:0]  s16;
  logic        iv16, ir16, or16;
  logic [31:0] y16;
  logic        c16, z16, e16, ov16;

  typedef struct {
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  alu_seq_param #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .carry(carry), .zero(zero), .err(err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .s(s16), .in_valid(iv16),
    .in_ready(ir16), .y(y16), .carry(c16), .zero(z16), .err(e16),
    .out_valid(ov16), .out_ready(or16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pops the oldest expectation once out_valid is seen, then exercises hold and release
  task automatic checkOutput(input string tag, input int lat, input int hold);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_lat"},   lat,       e.lat);
    check({tag, "_y"},     y,         e.y);
    check({tag, "_carry"}, carry,     e.c);
    check({tag, "_zero"},  zero,      e.z);
    check({tag, "_err"},   err,       e.e);
    check({tag, "_inrdy"}, in_ready,  1'b0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ov"}, out_valid, 1'b1);
      check({tag, "_hold_y"},  y,         e.y);
      check({tag, "_hold_ir"}, in_ready,  1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 8'h11; b = 8'h22; s = 4'h0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_rel_ov"}, out_valid, 1'b0);
    check({tag, "_rel_ir"}, in_ready,  1'b1);
    check({tag, "_rel_y"},  y,         e.y);
    @(posedge clk); #1;
    check({tag, "_noacc"},  out_valid, 1'b0);
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                               input logic [3:0] ts, input logic [15:0] ey, input logic ec,
                               input logic ez, input logic ee, input int lat, input int hold);
    exp_t e;
    int n;
    e.y = ey; e.c = ec; e.z = ez; e.e = ee; e.lat = lat;
    sbq.push_back(e);
    @(negedge clk);
    a = ta; b = tb; s = ts; in_valid = 1'b1;
    check({tag, "_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; s = ~ts;
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, n, hold);
  endtask

  initial begin
    int n;
    rst = 1'b1; a = '0; b = '0; s = '0; in_valid = 1'b0; out_ready = 1'b0;
    a16 = '0; b16 = '0; s16 = '0; iv16 = 1'b0; or16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_y",     y,         16'h0000);
    check("rst_ov",    out_valid, 1'b0);
    check("rst_flags", {carry, zero, err}, 3'b000);
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst_ir", in_ready, 1'b1);

    applyStimulus("add",    8'hEE, 8'hEE, 4'h0, 16'h01DC, 1'b1, 1'b0, 1'b0, 1, 0);
    applyStimulus("mul",    8'hEE, 8'hEE, 4'h2, 16'hDD44, 1'b0, 1'b0, 1'b0, 9, 0);
    applyStimulus("div",    8'hEE, 8'h05, 4'h3, 16'h032F, 1'b0, 1'b0, 1'b0, 9, 0);
    applyStimulus("div0",   8'hEE, 8'h00, 4'h3, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1, 0);
    applyStimulus("subz",   8'h05, 8'h05, 4'h1, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 5);
    applyStimulus("subb",   8'h03, 8'h05, 4'h1, 16'h01FE, 1'b1, 1'b0, 1'b0, 1, 0);
    applyStimulus("and",    8'hF0, 8'h3C, 4'h4, 16'h0030, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("or",     8'hF0, 8'h3C, 4'h5, 16'h00FC, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("xor",    8'hF0, 8'h3C, 4'h6, 16'h00CC, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("not",    8'h0F, 8'h00, 4'h7, 16'h00F0, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("shl",    8'h81, 8'h09, 4'h8, 16'h0002, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("shr",    8'h81, 8'h03, 4'h9, 16'h0010, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("rotl",   8'h81, 8'h01, 4'hA, 16'h0003, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("rotr",   8'h81, 8'h01, 4'hB, 16'h00C0, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("cmpgt",  8'h05, 8'h03, 4'hC, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 0);
    applyStimulus("cmple",  8'h03, 8'h05, 4'hC, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 0);
    applyStimulus("inc",    8'hFF, 8'h00, 4'hD, 16'h0100, 1'b1, 1'b0, 1'b0, 1, 0);
    applyStimulus("dec",    8'h00, 8'h00, 4'hE, 16'h01FF, 1'b1, 1'b0, 1'b0, 1, 0);
    applyStimulus("passb",  8'h12, 8'h00, 4'hF, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 0);
    applyStimulus("mulz",   8'h00, 8'h7B, 4'h2, 16'h0000, 1'b0, 1'b1, 1'b0, 9, 2);
    applyStimulus("divsm",  8'h05, 8'hEE, 4'h3, 16'h0500, 1'b0, 1'b0, 1'b0, 9, 0);

    // Reset in the middle of a multiply must abort it without a result
    @(negedge clk);
    a = 8'hEE; b = 8'hEE; s = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("abort_ov", out_valid, 1'b0);
    check("abort_y",  y,         16'h0000);
    @(negedge clk) rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      check("abort_nores", out_valid, 1'b0);
    end
    applyStimulus("postrst", 8'h01, 8'h02, 4'h0, 16'h0003, 1'b0, 1'b0, 1'b0, 1, 0);

    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; s16 = 4'h2; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 1;
    while (ov16 !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("w16_lat",   n,   17);
    check("w16_y",     y16, 32'hFFFE0001);
    check("w16_flags", {c16, z16, e16}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port a  input  WIDTH  operand A.
REQ-005 SHALL have port b  input  WIDTH  operand B.
REQ-006 SHALL have port s  input  4  opcode.
REQ-007 SHALL have port in_valid  input  1  operands/opcode valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a new operation.
REQ-009 SHALL have port y  output  2*WIDTH  registered result.
REQ-010 SHALL have port carry  output  1  carry/borrow flag.
REQ-011 SHALL have port zero  output  1  result-equals-zero flag.
REQ-012 SHALL have port err  output  1  divide-by-zero flag.
REQ-013 SHALL have port out_valid  output  1  y/carry/zero/err valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-016 SHALL accept an operation on a rising edge with in_valid=1 and in_ready=1, capturing a, b, s; later input changes ignored until next accept.
REQ-017 SHALL decode s: 0 add, 1 sub (a-b), 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not a, 8 shl a by b[log2(WIDTH)-1:0], 9 logical shr, A rotl, B rotr, C compare (y=1 if a>b unsigned else 0), D a+1, E a-1, F pass b.
REQ-018 SHALL, for single-cycle opcodes, go IDLE->DONE on the accepting edge (out_valid high 1 cycle after accept).
REQ-019 SHALL, for mul (shift-add) and div (restoring), go IDLE->BUSY, spend exactly WIDTH cycles in BUSY, then DONE (out_valid high WIDTH+1 cycles after accept).
REQ-020 SHALL zero-extend all non-mul/div results into y; add/sub/inc/dec SHALL place carry-out/borrow in y[WIDTH] and in carry; carry=0 for all other ops.
REQ-021 SHALL produce mul as unsigned full 2*WIDTH-bit product; div as y[WIDTH-1:0]=quotient, y[2*WIDTH-1:WIDTH]=remainder, unsigned.
REQ-022 SHALL, for div with b=0, skip BUSY, go DONE after 1 cycle with y all ones, err=1, carry=0, zero=0; err=0 for all other results.
REQ-023 SHALL compute zero=1 iff y==0 over full 2*WIDTH bits.
REQ-024 SHALL hold y and flags stable in DONE while out_ready=0; on edge with out_ready=1 SHALL go DONE->IDLE, deassert out_valid, retain y value.
REQ-025 SHALL NOT accept a new operation in the cycle the result is consumed (one IDLE cycle minimum between operations).
REQ-026 SHALL ignore in_valid in BUSY and DONE; out_ready in IDLE/BUSY has no effect.

Reset
REQ-027 SHALL on rst=1 immediately force IDLE, y=0, carry=0, zero=0, err=0, out_valid=0, clear internal mul/div registers; in_ready=1 once rst deasserts.
REQ-028 SHALL abort any BUSY or DONE operation on reset with no result delivered.

Verification
REQ-029 WIDTH=8, a=0xEE b=0xEE s=0 -> out_valid after 1 cycle, y=0x01DC, carry=1, zero=0.
REQ-030 WIDTH=8, a=0xEE b=0xEE s=2 -> in_ready low 9 cycles, out_valid after 9 cycles, y=0xDD44, carry=0.
REQ-031 WIDTH=8, a=0xEE b=0x05 s=3 -> y=0x032F after 9 cycles; then b=0x00 s=3 -> y=0xFFFF, err=1 after 1 cycle.
REQ-032 WIDTH=8, a=0x05 b=0x05 s=1 with out_ready=0 for 5 cycles -> y=0x0000, zero=1, out_valid and y stable, in_ready=0 throughout; releases after out_ready=1.
REQ-033 Assert rst 4 cycles into a mul -> out_valid=0, y=0 immediately; after release new add 0x01+0x02 -> y=0x0003 after 1 cycle.
REQ-034 WIDTH=16 regression: a=0xFFFF b=0xFFFF s=2 -> y=0xFFFE0001 after 17 cycles.
